// File: rtl/mips_tlb_pkg.sv
// Shared definitions for the TLB refill path: PTE layout, TLB geometry,
// unmapped-segment bounds, fault cause codes and walker FSM encoding.
package mips_tlb_pkg;

    localparam int PTE_PFN_HI = 31;
    localparam int PTE_PFN_LO = 12;
    localparam int PTE_D      = 10;
    localparam int PTE_V      = 9;

    localparam int TLB_DEPTH  = 32;
    localparam int TLB_IDX_W  = 5;

    localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
    localparam logic [31:0] KSEG1_LAST = 32'hBFFF_FFFF;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_INVALID  = 2'd1,
        CAUSE_TIMEOUT  = 2'd2,
        CAUSE_UNMAPPED = 2'd3
    } fault_cause_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } walk_state_e;

endpackage

// File: rtl/tlb_victim_ptr.sv
// Round-robin TLB victim selector; wraps from the last slot back to the
// first non-wired slot so wired entries are never replaced.
module tlb_victim_ptr
    import mips_tlb_pkg::*;
#(
    parameter int WIRED = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 advance,
    output logic [TLB_IDX_W-1:0] ptr
);

    localparam logic [TLB_IDX_W-1:0] FLOOR    = TLB_IDX_W'(WIRED);
    localparam logic [TLB_IDX_W-1:0] LAST_IDX = TLB_IDX_W'(TLB_DEPTH - 1);

    // Victim pointer register; with WIRED at the last slot it stays there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= FLOOR;
        end else if (advance) begin
            ptr <= (ptr == LAST_IDX) ? FLOOR : ptr + TLB_IDX_W'(1);
        end else begin
            ptr <= ptr;
        end
    end

endmodule

// File: rtl/tlb_refill_walker.sv
// Hardware TLB refill engine: fetches the PTE for a missed virtual page and
// writes it into a round-robin victim slot, or reports a fault.
module tlb_refill_walker
    import mips_tlb_pkg::*;
#(
    parameter int          WIRED          = 4,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] KSEG_LO        = KSEG0_BASE,
    parameter logic [31:0] KSEG_HI        = KSEG1_LAST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_valid,
    input  logic [31:0] miss_vaddr,
    output logic        miss_ready,
    input  logic [31:0] ptbase,
    input  logic        abort,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        tlb_write_enable,
    output logic [4:0]  tlb_write_index,
    output logic [31:0] tlb_write_tag,
    output logic [31:0] tlb_write_data,
    output logic        refill_done,
    output logic        refill_fault,
    output logic [1:0]  fault_cause,
    output logic        busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    walk_state_e            state_r, next_s;
    fault_cause_e           cause_r, cause_next_s;
    logic [19:0]            vpn_r;
    logic [31:0]            ptbase_r;
    logic [31:0]            pte_r;
    logic [CNT_W-1:0]       tmo_cnt_r;
    logic [TLB_IDX_W-1:0]   victim_s;
    logic                   accept_s;
    logic                   capture_s;
    logic                   unmapped_s;
    logic                   tmo_hit_s;

    assign unmapped_s = (miss_vaddr >= KSEG_LO) && (miss_vaddr <= KSEG_HI);
    assign tmo_hit_s  = (tmo_cnt_r == TMO_LAST);

    tlb_victim_ptr #(.WIRED(WIRED)) u_victim (
        .clk     (clk),
        .rst     (rst),
        .advance (state_r == ST_WRITE),
        .ptr     (victim_s)
    );

    // Next-state selection; abort only short-circuits FETCH and FAULT.
    always_comb begin
        next_s       = state_r;
        cause_next_s = cause_r;
        accept_s     = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (miss_valid) begin
                    accept_s = 1'b1;
                    if (unmapped_s) begin
                        next_s       = ST_FAULT;
                        cause_next_s = CAUSE_UNMAPPED;
                    end else begin
                        next_s = ST_FETCH;
                    end
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    next_s = ST_IDLE;
                end else if (mem_rvalid) begin
                    capture_s = 1'b1;
                    if (mem_rdata[PTE_V]) begin
                        next_s = ST_WRITE;
                    end else begin
                        next_s       = ST_FAULT;
                        cause_next_s = CAUSE_INVALID;
                    end
                end else if (tmo_hit_s) begin
                    next_s       = ST_FAULT;
                    cause_next_s = CAUSE_TIMEOUT;
                end else begin
                    next_s = ST_FETCH;
                end
            end
            ST_WRITE: next_s = ST_DONE;
            ST_DONE:  next_s = ST_IDLE;
            ST_FAULT: next_s = ST_IDLE;
            default:  next_s = ST_IDLE;
        endcase
    end

    // State, request context and fault cause registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cause_r  <= CAUSE_NONE;
            vpn_r    <= 20'h0_0000;
            ptbase_r <= 32'h0000_0000;
            pte_r    <= 32'h0000_0000;
        end else begin
            state_r  <= next_s;
            cause_r  <= cause_next_s;
            vpn_r    <= accept_s  ? miss_vaddr[31:12] : vpn_r;
            ptbase_r <= accept_s  ? ptbase            : ptbase_r;
            pte_r    <= capture_s ? mem_rdata         : pte_r;
        end
    end

    // Timeout counter: cleared on accept, counts FETCH cycles with no response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= '0;
        end else if (accept_s) begin
            tmo_cnt_r <= '0;
        end else if ((state_r == ST_FETCH) && !mem_rvalid) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    assign miss_ready       = (state_r == ST_IDLE);
    assign busy             = (state_r != ST_IDLE);
    assign mem_req          = (state_r == ST_FETCH);
    assign mem_addr         = mem_req ? (ptbase_r + {10'b0, vpn_r, 2'b00}) : 32'h0000_0000;
    assign tlb_write_enable = (state_r == ST_WRITE);
    assign tlb_write_index  = tlb_write_enable ? victim_s : 5'd0;
    assign tlb_write_tag    = tlb_write_enable ? {vpn_r, 12'h000} : 32'h0000_0000;
    assign tlb_write_data   = tlb_write_enable ? pte_r : 32'h0000_0000;
    assign refill_done      = (state_r == ST_DONE);
    assign refill_fault     = (state_r == ST_FAULT) && !abort;
    assign fault_cause      = refill_fault ? cause_r : CAUSE_NONE;

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Directed self-checking bench for tlb_refill_walker (default parameters).
module tb_tlb_refill_walker;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_valid;
    logic [31:0] miss_vaddr;
    logic        miss_ready;
    logic [31:0] ptbase;
    logic        abort;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        tlb_write_enable;
    logic [4:0]  tlb_write_index;
    logic [31:0] tlb_write_tag;
    logic [31:0] tlb_write_data;
    logic        refill_done;
    logic        refill_fault;
    logic [1:0]  fault_cause;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [4:0]  exp_victim;

    tlb_refill_walker dut (
        .clk              (clk),
        .rst              (rst),
        .miss_valid       (miss_valid),
        .miss_vaddr       (miss_vaddr),
        .miss_ready       (miss_ready),
        .ptbase           (ptbase),
        .abort            (abort),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata),
        .tlb_write_enable (tlb_write_enable),
        .tlb_write_index  (tlb_write_index),
        .tlb_write_tag    (tlb_write_tag),
        .tlb_write_data   (tlb_write_data),
        .refill_done      (refill_done),
        .refill_fault     (refill_fault),
        .fault_cause      (fault_cause),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a miss at a negedge; returns at the negedge of FETCH cycle 1.
    task automatic accept(input logic [31:0] va, input logic [31:0] base);
        miss_valid = 1'b1;
        miss_vaddr = va;
        ptbase     = base;
        @(negedge clk);
        miss_valid = 1'b0;
    endtask

    // Full successful refill with the response in FETCH cycle 'lat'.
    task automatic do_refill(input string tag, input logic [31:0] va, input logic [31:0] base,
                             input logic [31:0] pte, input int lat);
        logic [31:0] exp_addr;
        exp_addr = base + ((va >> 12) << 2);
        accept(va, base);
        check({tag, ".mem_req"}, {31'b0, mem_req}, 32'd1);
        check({tag, ".mem_addr"}, mem_addr, exp_addr);
        repeat (lat - 1) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = pte;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check({tag, ".we"}, {31'b0, tlb_write_enable}, 32'd1);
        check({tag, ".index"}, {27'b0, tlb_write_index}, {27'b0, exp_victim});
        check({tag, ".tag"}, tlb_write_tag, va & 32'hFFFF_F000);
        check({tag, ".data"}, tlb_write_data, pte);
        exp_victim = (exp_victim == 5'd31) ? 5'd4 : exp_victim + 5'd1;
        @(negedge clk);
        check({tag, ".done"}, {30'b0, tlb_write_enable, refill_done}, 32'd1);
        @(negedge clk);
        check({tag, ".idle"}, {30'b0, miss_ready, busy}, 32'd2);
    endtask

    initial begin
        rst        = 1'b1;
        miss_valid = 1'b0;
        miss_vaddr = 32'h0;
        ptbase     = 32'h0;
        abort      = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        exp_victim = 5'd4;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("reset.ready_busy", {30'b0, miss_ready, busy}, 32'd2);
        check("reset.outputs", {26'b0, mem_req, tlb_write_enable, refill_done, refill_fault, fault_cause},
              32'd0);
        check("reset.addr_idx", mem_addr | {27'b0, tlb_write_index}, 32'd0);

        // Valid refill with hand-computed address, response on cycle 3
        accept(32'h0040_3123, 32'h0010_0000);
        check("valid.mem_addr", mem_addr, 32'h0010_100C);
        check("valid.miss_ready", {31'b0, miss_ready}, 32'd0);
        repeat (2) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0012_3600;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("valid.we", {31'b0, tlb_write_enable}, 32'd1);
        check("valid.index", {27'b0, tlb_write_index}, 32'd4);
        check("valid.tag", tlb_write_tag, 32'h0040_3000);
        check("valid.data", tlb_write_data, 32'h0012_3600);
        exp_victim = 5'd5;
        @(negedge clk);
        check("valid.done", {30'b0, tlb_write_enable, refill_done}, 32'd1);
        check("valid.write_zero", tlb_write_tag | tlb_write_data, 32'd0);
        @(negedge clk);
        check("valid.idle", {30'b0, miss_ready, refill_done}, 32'd2);

        // Invalid PTE
        accept(32'h0040_3123, 32'h0010_0000);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0012_3400;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("invalid.fault", {29'b0, tlb_write_enable, refill_fault, refill_done}, 32'd2);
        check("invalid.cause", {30'b0, fault_cause}, 32'd1);
        @(negedge clk);
        check("invalid.idle", {30'b0, miss_ready, refill_fault}, 32'd2);

        // Timeout after exactly 64 FETCH cycles
        accept(32'h0000_5000, 32'h0020_0000);
        repeat (63) @(negedge clk);
        check("timeout.cycle64", {30'b0, mem_req, refill_fault}, 32'd2);
        @(negedge clk);
        check("timeout.fault", {30'b0, mem_req, refill_fault}, 32'd1);
        check("timeout.cause", {30'b0, fault_cause}, 32'd2);
        @(negedge clk);

        // Response on FETCH cycle 64 wins over the timeout
        do_refill("tmo_edge", 32'h0000_5000, 32'h0020_0000, 32'h0ABC_D200, 64);

        // Unmapped: first, last, and first address above the window
        accept(32'h8000_1000, 32'h0010_0000);
        check("unmapped.fault", {29'b0, mem_req, refill_fault, refill_done}, 32'd2);
        check("unmapped.cause", {30'b0, fault_cause}, 32'd3);
        @(negedge clk);
        accept(32'hBFFF_FFFF, 32'h0010_0000);
        check("unmapped_hi.cause", {29'b0, mem_req, fault_cause}, 32'd3);
        @(negedge clk);
        accept(32'hC000_0000, 32'h0010_0000);
        check("mapped_c0.fetch", {30'b0, mem_req, refill_fault}, 32'd2);
        check("mapped_c0.addr", mem_addr, 32'h0040_0000);

        // Abort during FETCH, then a late response is ignored
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort.idle", {30'b0, miss_ready, busy}, 32'd2);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0012_3600;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("abort.late_rvalid", {28'b0, busy, tlb_write_enable, refill_done, refill_fault}, 32'd0);
        do_refill("after_abort", 32'h1234_5678, 32'h0000_1000, 32'h0000_0200, 1);

        // Victim wrap: 7..31 then back to 4
        for (int i = 0; i < 26; i++) begin
            do_refill("wrap", 32'h0001_0000 + (i << 12), 32'h0030_0000, 32'h0055_5200 + (i << 12), 2);
        end
        check("wrap.model", {27'b0, exp_victim}, 32'd5);

        // Reset mid-FETCH is immediate and restores the victim pointer
        accept(32'h0040_3123, 32'h0010_0000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid.outputs", {27'b0, miss_ready, busy, mem_req, tlb_write_enable, refill_fault}, 32'd16);
        check("rst_mid.addr", mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_victim = 5'd4;
        do_refill("after_rst", 32'h0040_3123, 32'h0010_0000, 32'h0012_3600, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tlb_refill_walker.md
Name: tlb_refill_walker

Overview:
- Hardware TLB refill engine: the write-side counterpart of the TLB lookup path.
- Accepts a translation-miss request, reads the page-table entry (PTE) from memory, and writes tag/PTE into a TLB slot via the TLB write port (index/tag/data/enable).
- Reports refill completion or a fault to the core.
- Sits between the core's miss/exception logic, the TLB write port, and a memory read port.

Parameters:
- WIRED, 4: entries 0..WIRED-1 are never chosen as victims; legal range 0..31.
- TIMEOUT_CYCLES, 64: FETCH cycles without mem_rvalid before a timeout fault; minimum 1.
- KSEG_LO, 32'h8000_0000: first unmapped address.
- KSEG_HI, 32'hBFFF_FFFF: last unmapped address.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- miss_valid  in  1  refill request.
- miss_vaddr  in  32  faulting virtual address.
- miss_ready  out  1  high only in IDLE.
- ptbase  in  32  page-table base physical address; sampled at accept.
- abort  in  1  cancels an in-flight walk.
- mem_req  out  1  read request; held high throughout FETCH.
- mem_addr  out  32  PTE physical address.
- mem_rvalid  in  1  one-cycle response strobe.
- mem_rdata  in  32  PTE: [31:12] PFN, [10] D, [9] V.
- tlb_write_enable  out  1  one-cycle write strobe.
- tlb_write_index  out  5  victim slot.
- tlb_write_tag  out  32  {vpn, 12'b0}.
- tlb_write_data  out  32  PTE, unmodified.
- refill_done  out  1  one-cycle success pulse.
- refill_fault  out  1  one-cycle fault pulse.
- fault_cause  out  2  0 none, 1 invalid PTE, 2 timeout, 3 unmapped address; valid with refill_fault.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state IDLE; victim pointer = WIRED; timeout counter = 0; all outputs 0 except miss_ready = 1.
- FSM states: IDLE, FETCH, WRITE, DONE, FAULT.
- IDLE:
  - On a clk edge with miss_valid=1, latch vpn = miss_vaddr[31:12] and ptbase.
  - If KSEG_LO <= miss_vaddr <= KSEG_HI: go to FAULT, cause 3, no memory access.
  - Otherwise: go to FETCH.
- FETCH:
  - mem_req = 1; mem_addr = ptbase + {vpn, 2'b00}, 32-bit modulo wrap with no overflow detection.
  - On mem_rvalid: capture mem_rdata. If PTE[9]=1 go to WRITE; else go to FAULT, cause 1.
  - Timeout counter clears on entry and increments each FETCH cycle without mem_rvalid. When it reaches TIMEOUT_CYCLES: go to FAULT, cause 2.
  - mem_rvalid and timeout in the same cycle: mem_rvalid wins.
- WRITE:
  - tlb_write_enable = 1 for exactly one cycle; index = victim pointer; tag = {vpn, 12'b0}; data = PTE.
  - Victim pointer then advances: 31 wraps to WIRED.
  - If WIRED = 31, the pointer stays at 31.
  - Next state: DONE.
- DONE: refill_done = 1 for one cycle; next state IDLE.
- FAULT: refill_fault = 1 and fault_cause valid for one cycle; no TLB write; next state IDLE.
- Latency: accept edge, then FETCH on the next cycle; mem_rvalid at FETCH cycle k; WRITE at k+1; DONE at k+2; IDLE at k+3.
- abort:
  - In FETCH or FAULT: next state IDLE, no pulses.
  - In WRITE: ignored; the write completes.
  - In DONE: ignored.
  - A mem_rvalid arriving in IDLE or after an abort is ignored.
- A new miss is accepted only in IDLE; miss_valid in other states is not acknowledged.
- rst asserted mid-walk: immediate IDLE and victim pointer reset; no TLB write or pulse is emitted.
- tlb_write_* fields are 0 whenever tlb_write_enable = 0.

Decomposition:
- Shared package (mips_tlb_pkg):
  - PTE field positions (PFN 31:12, D 10, V 9).
  - TLB depth 32 and index width 5.
  - KSEG0/KSEG1 bounds.
  - fault_cause encodings.
  - FSM state encoding.
- Sub-module: tlb_victim_ptr, a wrapping round-robin counter with WIRED floor and an advance input.

Test Plan:
- Valid refill: ptbase=0x0010_0000, miss_vaddr=0x0040_3123 -> mem_addr=0x0010_100C. mem_rdata=0x0012_3600 after 3 cycles -> one-cycle write with index=4, tag=0x0040_3000, data=0x0012_3600; refill_done one cycle later.
- Invalid PTE: mem_rdata=0x0012_3400 (V=0) -> refill_fault with cause 1; no tlb_write_enable; victim pointer unchanged.
- Timeout: mem_rvalid never asserts -> fault cause 2 after exactly 64 FETCH cycles. Repeat with mem_rvalid on cycle 64 -> success path.
- Unmapped: miss_vaddr=0x8000_1000 -> fault cause 3 one cycle after accept; mem_req stays 0.
- Victim wrap: 29 consecutive successful refills -> indices 4..31, then 4.
- Abort and reset: abort during FETCH then a late mem_rvalid -> no write and no pulse; the next miss is accepted. rst asserted mid-FETCH -> outputs return to reset values asynchronously; after release, the victim index is 4.
